// File: rtl/routine_arbiter.sv
// routine_arbiter: selects one of CHANNELS display routines, holds it until it
// finishes and a minimum dwell has passed, then chooses the next one by mode.
// The chosen routine is told to restart through a one-cycle NewChoice pulse.
module routine_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 2,
    parameter int DATA_W    = 46,
    parameter int MIN_DWELL = 16,
    parameter int DWELL_W   = 8
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [1:0]                      Mode,
    input  logic [SEL_W-1:0]                Select,
    input  logic [CHANNELS*(DATA_W+1)-1:0]  Routines,
    output logic                            NewChoice,
    output logic [SEL_W-1:0]                Active,
    output logic [DATA_W-1:0]               Out
);

    typedef enum logic {LAUNCH = 1'b0, RUN = 1'b1} state_t;

    localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DWELL_W-1:0] DW_MAX  = DWELL_W'(MIN_DWELL);

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_ROBIN  = 2'b01;
    localparam logic [1:0] MODE_FIXED  = 2'b10;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     active_q, active_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 nc_q, nc_d;
    logic [DATA_W-1:0]    out_q, out_d;

    logic [DATA_W-1:0]    sel_data;
    logic                 sel_busy;
    logic [SEL_W-1:0]     cand;
    logic [SEL_W-1:0]     next_rr;
    logic [DWELL_W-1:0]   dwell_inc;

    // Pick out the busy flag and display data of the currently active channel.
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active_q == SEL_W'(i)) begin
                sel_data = Routines[i*(DATA_W+1) +: DATA_W];
                sel_busy = Routines[i*(DATA_W+1) + DATA_W];
            end
        end
    end

    // Candidate channel (out-of-range requests fall back to channel 0) and
    // the round-robin successor, plus the saturating dwell count.
    always_comb begin
        cand      = (Select > LAST_CH) ? '0 : Select;
        next_rr   = (active_q == LAST_CH) ? '0 : active_q + SEL_W'(1);
        dwell_inc = (dwell_q >= DW_MAX) ? DW_MAX : dwell_q + DWELL_W'(1);
    end

    // Next-state logic: LAUNCH restarts the routine, RUN waits for the dwell
    // to reach its minimum and then applies the mode's switch rule.
    // The decision uses the incremented dwell so pulses are MIN_DWELL+1 apart.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        dwell_d  = dwell_q;
        nc_d     = 1'b0;
        out_d    = sel_data;
        case (state_q)
            LAUNCH: begin
                nc_d    = 1'b1;
                dwell_d = '0;
                state_d = RUN;
            end
            default: begin
                dwell_d = dwell_inc;
                if (dwell_inc == DW_MAX) begin
                    case (Mode)
                        MODE_RANDOM: begin
                            if (!sel_busy) begin
                                active_d = cand;
                                state_d  = LAUNCH;
                            end
                        end
                        MODE_ROBIN: begin
                            if (!sel_busy) begin
                                active_d = next_rr;
                                state_d  = LAUNCH;
                            end
                        end
                        MODE_FIXED: begin
                            if (cand != active_q) begin
                                active_d = cand;
                                state_d  = LAUNCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and output registers; everything returns to channel 0 / LAUNCH on reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= LAUNCH;
            active_q <= '0;
            dwell_q  <= '0;
            nc_q     <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            dwell_q  <= dwell_d;
            nc_q     <= nc_d;
            out_q    <= out_d;
        end
    end

    assign NewChoice = nc_q;
    assign Active    = active_q;
    assign Out       = out_q;

endmodule

// File: tb/tb_routine_arbiter.sv
// Directed bench for routine_arbiter: a 4-channel instance with MIN_DWELL=4
// and a 3-channel instance for the clamping and wrap cases.
module tb_routine_arbiter;

    logic               Clock;
    logic               Reset;
    logic [1:0]         Mode;
    logic [1:0]         Select;
    logic [3:0]         busy;
    logic [4*47-1:0]    Routines;
    logic               NewChoice;
    logic [1:0]         Active;
    logic [45:0]        Out;

    logic               Reset3;
    logic [1:0]         Mode3;
    logic [1:0]         Select3;
    logic [2:0]         busy3;
    logic [3*47-1:0]    Routines3;
    logic               NewChoice3;
    logic [1:0]         Active3;
    logic [45:0]        Out3;

    int total = 0;
    int bad   = 0;

    assign Routines  = {busy[3], 46'd4, busy[2], 46'd3, busy[1], 46'd2, busy[0], 46'd1};
    assign Routines3 = {busy3[2], 46'd3, busy3[1], 46'd2, busy3[0], 46'd1};

    routine_arbiter #(.CHANNELS(4), .SEL_W(2), .DATA_W(46), .MIN_DWELL(4), .DWELL_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .Mode(Mode), .Select(Select), .Routines(Routines),
        .NewChoice(NewChoice), .Active(Active), .Out(Out)
    );

    routine_arbiter #(.CHANNELS(3), .SEL_W(2), .DATA_W(46), .MIN_DWELL(4), .DWELL_W(8)) dut3 (
        .Clock(Clock), .Reset(Reset3), .Mode(Mode3), .Select(Select3), .Routines(Routines3),
        .NewChoice(NewChoice3), .Active(Active3), .Out(Out3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Mode = 2'b01; Select = 2'd0; busy = 4'b0000;
        Reset3 = 1'b1; Mode3 = 2'b00; Select3 = 2'd3; busy3 = 3'b000;
        #1;
        chk("rst_active", Active, 0);
        chk("rst_out", Out, 0);
        chk("rst_newchoice", NewChoice, 0);

        // Round-robin from reset, all channels idle
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge Clock);
            chk("rr_active", Active, 64'((k / 5) % 4));
            chk("rr_newchoice", NewChoice, 64'(k % 5 == 1));
            chk("rr_out", Out, 64'(((k - 1) / 5) % 4 + 1));
        end
        repeat (11) @(negedge Clock);
        chk("rr_active_before_reset", Active, 2);

        // Asynchronous reset in the middle of RUN
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_active", Active, 0);
        chk("async_rst_out", Out, 0);
        chk("async_rst_newchoice", NewChoice, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_rst_newchoice", NewChoice, 1);
        @(negedge Clock);
        chk("post_rst_out", Out, 1);
        chk("post_rst_newchoice_low", NewChoice, 0);

        // Random mode, channel 0 busy for 20 cycles, Select=3
        Reset = 1'b1;
        @(negedge Clock);
        Mode = 2'b00; Select = 2'd3; busy = 4'b0001;
        Reset = 1'b0;
        @(negedge Clock);
        chk("rnd_launch_pulse", NewChoice, 1);
        for (int k = 2; k <= 20; k++) begin
            @(negedge Clock);
            chk("rnd_busy_active", Active, 0);
            chk("rnd_busy_newchoice", NewChoice, 0);
        end
        busy = 4'b0000;
        @(negedge Clock);
        chk("rnd_switch_active", Active, 3);
        @(negedge Clock);
        chk("rnd_switch_newchoice", NewChoice, 1);
        chk("rnd_switch_out", Out, 4);
        @(negedge Clock);
        chk("rnd_pulse_one_cycle", NewChoice, 0);

        // Fixed mode overrides a busy channel, then holds with no relaunch
        Reset = 1'b1;
        @(negedge Clock);
        Mode = 2'b10; Select = 2'd1; busy = 4'b0001;
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        chk("fix_before_dwell", Active, 0);
        @(negedge Clock);
        chk("fix_override_active", Active, 1);
        @(negedge Clock);
        chk("fix_override_newchoice", NewChoice, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            chk("fix_hold_newchoice", NewChoice, 0);
            chk("fix_hold_active", Active, 1);
        end

        // Move to channel 2, then hold mode with random Select and Busy
        Select = 2'd2;
        @(negedge Clock);
        chk("fix_to_two", Active, 2);
        @(negedge Clock);
        chk("fix_to_two_newchoice", NewChoice, 1);
        Mode = 2'b11;
        for (int k = 0; k < 100; k++) begin
            Select = 2'($urandom);
            busy   = 4'($urandom);
            @(negedge Clock);
            chk("hold_active", Active, 2);
            chk("hold_newchoice", NewChoice, 0);
        end

        // Three-channel instance: clamped random pick, then wrap in round-robin
        @(negedge Clock);
        Reset3 = 1'b0;
        repeat (4) @(negedge Clock);
        @(negedge Clock);
        chk("ch3_clamp_active", Active3, 0);
        @(negedge Clock);
        chk("ch3_clamp_relaunch", NewChoice3, 1);
        Mode3 = 2'b10; Select3 = 2'd2;
        repeat (4) @(negedge Clock);
        chk("ch3_fixed_two", Active3, 2);
        Mode3 = 2'b01;
        repeat (4) @(negedge Clock);
        chk("ch3_rr_hold", Active3, 2);
        chk("ch3_out", Out3, 3);
        @(negedge Clock);
        chk("ch3_rr_wrap", Active3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/routine_arbiter.md
Name: routine_arbiter

Overview:
- Parametrised successor to the four-way routine selector.
- Takes CHANNELS packed routine buses. Each bus is one Busy flag plus DATA_W display bits.
- Holds the active routine until it signals completion and a minimum dwell time has elapsed, then picks the next routine by mode (random, round-robin, fixed, hold).
- Pulses NewChoice so the chosen routine restarts. Sits between the routine generators and the LED/7-segment pin split.

Parameters:
CHANNELS, 4, number of routine inputs (2..16)
SEL_W, 2, width of Select and Active; must satisfy 2**SEL_W >= CHANNELS
DATA_W, 46, display bits per routine (LedRed/LedGrn/Disp3..0 packing)
MIN_DWELL, 16, minimum cycles a routine stays active before any switch (>=1)
DWELL_W, 8, dwell counter width; must hold MIN_DWELL

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Mode  input  2  00 random, 01 round-robin, 10 fixed, 11 hold
Select  input  SEL_W  random bits (mode 00) or requested channel (mode 10)
Routines  input  CHANNELS*(DATA_W+1)  channel i = Routines[i*(DATA_W+1) +: DATA_W+1]; top bit Busy, rest data
NewChoice  output  1  one-cycle pulse: routines restart
Active  output  SEL_W  index of the current routine
Out  output  DATA_W  registered display data of the active routine

Behaviour:
- Reset (async, any time, including mid-switch): Active=0, Out=0, NewChoice=0, dwell=0, state=LAUNCH. The first cycle after release is LAUNCH.
- States:
  - LAUNCH: NewChoice=1 for exactly one cycle; dwell<=0; go to RUN.
  - RUN: NewChoice=0; dwell increments each cycle, saturating at MIN_DWELL.
- Out is registered: Out <= data of Routines[Active] every cycle in both states, so it shows channel data one cycle later. In LAUNCH, Active already holds the new index.
- Sanitised candidate: cand = Select if Select < CHANNELS, else 0.
- Switch decision (RUN only), evaluated when dwell == MIN_DWELL:
  - Mode 00: if Busy[Active]==0, Active <= cand and go to LAUNCH. Re-picking the same channel still relaunches (NewChoice pulses).
  - Mode 01: if Busy[Active]==0, Active <= (Active==CHANNELS-1) ? 0 : Active+1; go to LAUNCH.
  - Mode 10: if cand != Active, Active <= cand and go to LAUNCH, ignoring Busy (user override). If cand == Active, stay in RUN with no pulse, even when Busy==0.
  - Mode 11: never switch; Active frozen; no NewChoice.
- Mode and Select are sampled only at the decision edge. A change mid-dwell takes effect at the next decision.
- A Busy flag from a non-active channel never influences behaviour.
- NewChoice never asserts on two consecutive cycles. The minimum spacing between pulses is MIN_DWELL+1 cycles.
- Active is never >= CHANNELS.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
(Bench: CHANNELS=4, DATA_W=46, MIN_DWELL=4. Channel i data = 46'h0000_0000_00i + 1.)
- Reset in mid-RUN with Active=2: assert Reset -> Active=0, Out=0, NewChoice=0 immediately without a clock. After release: NewChoice=1 on the first edge, then Out=46'h1 on the following edge.
- Mode 01, all Busy=0 -> Active sequence 0,1,2,3,0. NewChoice pulses every 5 cycles. Out tracks Active with 1-cycle lag.
- Mode 00, Select=2'b11, Busy[0]=1 for 20 cycles then 0 -> Active stays 0 with no pulse while busy. Within 1 cycle of Busy dropping: Active=3, NewChoice=1 for one cycle.
- Mode 10, Select=1, Busy[0]=1 -> switch to 1 at dwell=4 despite Busy. Then hold Select=1 with Busy[1]=0 for 50 cycles -> no further NewChoice.
- Mode 11 from Active=2, toggle Select and all Busy lines for 100 cycles -> Active=2 throughout, NewChoice=0.
- CHANNELS=3 build, Mode 00, Select=3 -> Active=0 (clamped). Mode 01 from Active=2 -> Active=0.
